// File: rtl/phy_tx_arbiter_pkg.sv
// Shared definitions for the phy transmit arbiter: FSM encoding, counter width and
// index-width helper.
package phy_tx_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned BeatCountW = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request scanning from rr_ptr upward,
// wrapping modulo NumReq.
module phy_tx_arbiter_rr_pick
  import phy_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   winner,
  output logic              any
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = IdxW'((32'(rr_ptr) + k) % NumReq);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Burst round-robin arbiter sharing the phy transmit datapath among NUM_REQ requesters.
// Define PHY_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module phy_tx_arbiter
  import phy_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IdxW     = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [DATA_W-1:0]        data_in_tx,
  output logic                     valid_in_tx,
  output logic [IdxW-1:0]          gnt_idx,
  output logic [BeatCountW-1:0]    beat_count
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

`ifdef PHY_ARB_STRICT_PRIO_EN
  localparam bit StrictPrio = 1'b1;
`else
  localparam bit StrictPrio = 1'b0;
`endif

  arb_state_e            state_q;
  logic [IdxW-1:0]       gnt_idx_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [CntW-1:0]       beat_cnt_q;
  logic [DATA_W-1:0]     data_q;
  logic                  valid_q;
  logic [BeatCountW-1:0] beat_count_q;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   next_ptr;
  logic              any_req;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              accept;
  logic              burst_full;
  logic              burst_end;

  phy_tx_arbiter_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  // Ready depends only on state and grant so requesters never see a valid->ready loop.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == gnt_idx_q) begin
        sel_data     = req_data[i*DATA_W +: DATA_W];
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        req_ready[i] = (state_q == StBurst);
      end
    end
    accept     = (state_q == StBurst) && sel_valid;
    burst_full = (beat_cnt_q == CntW'(MAX_BURST - 1));
    burst_end  = !sel_valid || sel_last || burst_full;
    next_ptr   = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      gnt_idx_q    <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      beat_count_q <= '0;
    end else begin
      valid_q <= accept;
      data_q  <= accept ? sel_data : '0;
      if (accept && (beat_count_q != '1)) begin
        beat_count_q <= beat_count_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_idx_q  <= winner;
            beat_cnt_q <= '0;
            state_q    <= StBurst;
          end
        end
        StBurst: begin
          if (burst_end) begin
            state_q  <= StIdle;
            rr_ptr_q <= StrictPrio ? '0 : next_ptr;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_in_tx  = data_q;
  assign valid_in_tx = valid_q;
  assign gnt_idx     = gnt_idx_q;
  assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Randomized bench for phy_tx_arbiter: per-requester frame queues feed the DUT and a
// transaction-level arbitration model predicts the beat order and inter-beat gaps.
module tb_phy_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   data_in_tx;
  logic           valid_in_tx;
  logic [1:0]     gnt_idx;
  logic [15:0]    beat_count;

  always #5 clk = ~clk;

  phy_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .data_in_tx  (data_in_tx),
    .valid_in_tx (valid_in_tx),
    .gnt_idx     (gnt_idx),
    .beat_count  (beat_count)
  );

  // Each queue entry is {last, data}.
  bit [W:0]     rq [N][$];
  logic [W-1:0] exp_data[$];
  int           exp_req[$];
  int           exp_gap[$];

  int           mp;           // model round-robin pointer
  int           model_total;  // beats accepted since last reset
  int           seq;
  int           passed;
  int           total;
  int           idle_run;
  bit           mon_en;
  logic [N-1:0] last_acc;

  task automatic push_frame(input int i, input int len, input bit with_last);
    logic [W-1:0] d;
    for (int j = 0; j < len; j++) begin
      d = {8'(i), 8'(seq), 16'($urandom)};
      seq++;
      rq[i].push_back({with_last && (j == len - 1), d});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = rq[i][0][W-1:0];
        req_last[i]          = rq[i][0][W];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [W-1:0] d;
    int r;
    int g;
    if (!mon_en) return;
    if (valid_in_tx === 1'b1) begin
      if (exp_data.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat got data=%h want no beat", data_in_tx);
      end else begin
        d = exp_data.pop_front();
        r = exp_req.pop_front();
        g = exp_gap.pop_front();
        total++;
        if (data_in_tx !== d) $display("FAIL beat_data got %h want %h", data_in_tx, d);
        else passed++;
        total++;
        if (gnt_idx !== 2'(r)) $display("FAIL beat_gnt got %0d want %0d", gnt_idx, r);
        else passed++;
        if (g >= 0) begin
          total++;
          if (idle_run != g) $display("FAIL beat_gap got %0d want %0d", idle_run, g);
          else passed++;
        end
      end
      idle_run = 0;
    end else begin
      idle_run++;
    end
  endtask

  // One clock: sample at negedge, then let requesters retire accepted beats after posedge.
  task automatic tick();
    @(negedge clk);
    last_acc = req_valid & req_ready & {N{reset}};
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_acc[i]) void'(rq[i].pop_front());
    drive();
  endtask

  // Transaction model: each arbitration picks the first non-empty queue from mp, takes
  // beats until last, MAX_BURST, or the queue runs dry (dry release costs an extra cycle).
  task automatic build_model();
    bit [W:0] mq [N][$];
    bit [W:0] b;
    int gap;
    int w;
    int n;
    int idx;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    gap = -1;
    while (1'b1) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mp + k) % N;
        if (w < 0 && mq[idx].size() > 0) w = idx;
      end
      if (w < 0) break;
      n = 0;
      while (1'b1) begin
        b = mq[w].pop_front();
        exp_data.push_back(b[W-1:0]);
        exp_req.push_back(w);
        exp_gap.push_back(gap);
        gap = 0;
        n++;
        model_total++;
        if (b[W] || n == MB) begin
          gap = 1;
          break;
        end
        if (mq[w].size() == 0) begin
          gap = 2;
          break;
        end
      end
`ifdef PHY_ARB_STRICT_PRIO_EN
      mp = 0;
`else
      mp = (w + 1) % N;
`endif
    end
  endtask

  task automatic run_scenario(input string name);
    int budget;
    build_model();
    drive();
    idle_run = 0;
    budget   = 0;
    while (exp_data.size() > 0 && budget < 3000) begin
      tick();
      budget++;
    end
    total++;
    if (exp_data.size() != 0)
      $display("FAIL %s_drain got %0d beats left want 0", name, exp_data.size());
    else passed++;
    exp_data.delete();
    exp_req.delete();
    exp_gap.delete();
    repeat (3) tick();
    total++;
    if (beat_count !== 16'(model_total))
      $display("FAIL %s_beat_count got %0d want %0d", name, beat_count, model_total);
    else passed++;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) begin
      @(negedge clk);
      total++;
      if (req_ready !== '0) $display("FAIL reset_ready got %b want 0000", req_ready);
      else passed++;
      total++;
      if (valid_in_tx !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_in_tx);
      else passed++;
      total++;
      if (data_in_tx !== '0) $display("FAIL reset_data got %h want 0", data_in_tx);
      else passed++;
      total++;
      if (beat_count !== 16'd0) $display("FAIL reset_beat_count got %0d want 0", beat_count);
      else passed++;
      total++;
      if (gnt_idx !== 2'd0) $display("FAIL reset_gnt got %0d want 0", gnt_idx);
      else passed++;
    end
    @(posedge clk);
    #1;
    reset       = 1'b1;
    req_valid   = '0;
    mp          = 0;
    model_total = 0;
  endtask

  task automatic test_single_frame();
    push_frame(0, 3, 1'b1);
    run_scenario("single");
  endtask

  task automatic test_all_burst();
    for (int i = 0; i < N; i++) push_frame(i, 8, 1'b1);
    run_scenario("all_burst");
  endtask

  task automatic test_drop();
    push_frame(2, 1, 1'b0);
    push_frame(3, 2, 1'b1);
    run_scenario("drop");
  endtask

  task automatic test_reset_mid();
    int  b;
    bit  got;
    mon_en = 1'b0;
    push_frame(1, 4, 1'b0);
    drive();
    got = 1'b0;
    b   = 0;
    while (!got && b < 20) begin
      tick();
      got = last_acc[1];
      b++;
    end
    total++;
    if (!got) $display("FAIL reset_mid_grant got no accept want accept on req1");
    else passed++;
    reset = 1'b0;  // lands on the edge that would accept beat 2
    @(negedge clk);
    @(negedge clk);
    total++;
    if (valid_in_tx !== 1'b0) $display("FAIL reset_mid_valid got %b want 0", valid_in_tx);
    else passed++;
    total++;
    if (req_ready !== '0) $display("FAIL reset_mid_ready got %b want 0000", req_ready);
    else passed++;
    total++;
    if (beat_count !== 16'd0) $display("FAIL reset_mid_count got %0d want 0", beat_count);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    mp          = 0;
    model_total = 0;
    mon_en      = 1'b1;
    push_frame(1, 2, 1'b1);
    push_frame(0, 2, 1'b1);
    run_scenario("after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++)
          push_frame(i, $urandom_range(1, 6), $urandom_range(0, 3) != 0);
      end
      run_scenario("random");
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    passed    = 0;
    total     = 0;
    seq       = 0;
    mon_en    = 1'b1;
    test_reset();
    test_single_frame();
    test_all_burst();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
